// File: rtl/spin_majority_sampler.sv
// Majority-votes each bit of a SPINS-wide comparator vector over SAMPLES valid cycles
// and offers the voted spin states downstream over a valid/ready handshake.
module spin_majority_sampler #(
  parameter int SPINS   = 32,
  parameter int SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_valid,
  input  logic [SPINS-1:0] comparison,
  output logic             spins_valid,
  input  logic             spins_ready,
  output logic [SPINS-1:0] spins,
  output logic             busy
);

  localparam int CW = $clog2(SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt      [SPINS];
  logic [CW-1:0]    cnt_next [SPINS];
  logic [CW-1:0]    samp;
  logic [SPINS-1:0] vote;
  logic             last;

  // Vote on counts that already include this cycle's sample; doubling in CW+1 bits cannot overflow.
  always_comb begin
    last = (samp == CW'(SAMPLES - 1));
    vote = spins;
    for (int unsigned i = 0; i < SPINS; i++) begin
      cnt_next[i] = cnt[i] + CW'(comparison[i]);
      if ({cnt_next[i], 1'b0} > (CW + 1)'(SAMPLES))
        vote[i] = 1'b1;
      else if ({cnt_next[i], 1'b0} < (CW + 1)'(SAMPLES))
        vote[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spins       <= '0;
      spins_valid <= 1'b0;
      busy        <= 1'b0;
      samp        <= '0;
      for (int unsigned i = 0; i < SPINS; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= ACCUM;
            busy  <= 1'b1;
            samp  <= '0;
            for (int unsigned i = 0; i < SPINS; i++) cnt[i] <= '0;
          end
        end
        ACCUM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            samp  <= '0;
            for (int unsigned i = 0; i < SPINS; i++) cnt[i] <= '0;
          end else if (cmp_valid) begin
            samp <= samp + CW'(1);
            for (int unsigned i = 0; i < SPINS; i++) cnt[i] <= cnt_next[i];
            if (last) begin
              state       <= HOLD;
              spins       <= vote;
              spins_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state       <= IDLE;
            spins_valid <= 1'b0;
            busy        <= 1'b0;
          end else if (spins_ready) begin
            spins_valid <= 1'b0;
            if (start) begin
              state <= ACCUM;
              samp  <= '0;
              for (int unsigned i = 0; i < SPINS; i++) cnt[i] <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          spins_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spin_majority_sampler.sv
// Bench for spin_majority_sampler: SPINS=4/SAMPLES=4 against a tally model, plus a SAMPLES=1 instance.
module tb_spin_majority_sampler;

  localparam int N = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, cmp_valid, spins_ready;
  logic [N-1:0] comparison;
  logic         spins_valid, busy;
  logic [N-1:0] spins;

  logic         start1, abort1, cmp_valid1, spins_ready1;
  logic [N-1:0] comparison1;
  logic         spins_valid1, busy1;
  logic [N-1:0] spins1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spin_majority_sampler #(.SPINS(N), .SAMPLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cmp_valid(cmp_valid), .comparison(comparison),
    .spins_valid(spins_valid), .spins_ready(spins_ready),
    .spins(spins), .busy(busy)
  );

  spin_majority_sampler #(.SPINS(N), .SAMPLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .cmp_valid(cmp_valid1), .comparison(comparison1),
    .spins_valid(spins_valid1), .spins_ready(spins_ready1),
    .spins(spins1), .busy(busy1)
  );

  // Behavioural model: per-window tallies and a sample count, vote by integer comparison.
  bit           m_accum, m_hold, m_valid;
  logic [N-1:0] m_spins;
  int           tally [N];
  int           taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_accum = 0; m_hold = 0; m_valid = 0; m_spins = '0; taken = 0;
      for (int i = 0; i < N; i++) tally[i] = 0;
    end else if (m_hold) begin
      if (abort) begin
        m_hold = 0; m_valid = 0;
      end else if (spins_ready) begin
        m_hold = 0; m_valid = 0;
        if (start) begin
          m_accum = 1; taken = 0;
          for (int i = 0; i < N; i++) tally[i] = 0;
        end
      end
    end else if (m_accum) begin
      if (abort) begin
        m_accum = 0; taken = 0;
        for (int i = 0; i < N; i++) tally[i] = 0;
      end else if (cmp_valid) begin
        for (int i = 0; i < N; i++) tally[i] += int'(comparison[i]);
        taken++;
        if (taken == S) begin
          for (int i = 0; i < N; i++) begin
            if (2 * tally[i] > S) m_spins[i] = 1'b1;
            else if (2 * tally[i] < S) m_spins[i] = 1'b0;
          end
          m_valid = 1; m_hold = 1; m_accum = 0;
        end
      end
    end else if (start && !abort) begin
      m_accum = 1; taken = 0;
      for (int i = 0; i < N; i++) tally[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      tests += 3;
      if (spins !== m_spins) begin
        fails++; $display("FAIL model_spins t=%0t got %b want %b", $time, spins, m_spins);
      end
      if (spins_valid !== m_valid) begin
        fails++; $display("FAIL model_valid t=%0t got %b want %b", $time, spins_valid, m_valid);
      end
      if (busy !== (m_accum || m_hold)) begin
        fails++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, m_accum || m_hold);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed result.
  task automatic chk_out(input string name, input logic [N-1:0] s, input logic v, input logic b);
    chk({name, "_spins"}, 32'(spins), 32'(s));
    chk({name, "_valid"}, 32'(spins_valid), 32'(v));
    chk({name, "_busy"}, 32'(busy), 32'(b));
    chk({name, "_model"}, 32'(m_spins), 32'(s));
  endtask

  task automatic step(input logic st, input logic ab, input logic cv,
                      input logic [N-1:0] cmp, input logic rdy);
    start = st; abort = ab; cmp_valid = cv; comparison = cmp; spins_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic window(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N-1:0] d);
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, a, 0);
    step(0, 0, 1, b, 0);
    step(0, 0, 1, c, 0);
    step(0, 0, 1, d, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    start = 0; abort = 0; cmp_valid = 0; comparison = '0; spins_ready = 0;
    start1 = 0; abort1 = 0; cmp_valid1 = 0; comparison1 = '0; spins_ready1 = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    chk_out("reset", 4'b0000, 0, 0);

    // Majority: bit3 count 3, bit2 0, bits1/0 count 4
    window(4'b1011, 4'b1011, 4'b1011, 4'b0011);
    chk_out("vote_basic", 4'b1011, 1, 1);
    step(0, 0, 0, '0, 1);
    chk_out("accept", 4'b1011, 0, 0);

    // Ties keep prior value: bit3 tie (prior 1), bit2 tie (prior 0), bits1/0 count 1
    window(4'b1100, 4'b1100, 4'b0011, 4'b0000);
    chk_out("tie_mixed", 4'b1000, 1, 1);
    step(0, 0, 0, '0, 1);
    window(4'b0100, 4'b0100, 4'b0100, 4'b0100);
    chk_out("set_0100", 4'b0100, 1, 1);
    step(0, 0, 0, '0, 1);
    window(4'b0100, 4'b0100, 4'b0000, 4'b0000);
    chk_out("tie_keep", 4'b0100, 1, 1);
    step(0, 0, 0, '0, 1);

    // Gaps in cmp_valid do not count
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 0, 0, 4'b0000, 0);
    step(0, 0, 0, 4'b0000, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 0, 0, 4'b0000, 0);
    chk_out("gap_pending", 4'b0100, 0, 1);
    step(0, 0, 1, 4'b1111, 0);
    chk_out("gap_done", 4'b1111, 1, 1);

    // HOLD stalls with ready low, then back-to-back window
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1'(i & 1), 4'(i), 0);
      chk_out("hold_stable", 4'b1111, 1, 1);
    end
    step(1, 0, 0, '0, 1);
    chk_out("b2b_start", 4'b1111, 0, 1);
    step(0, 0, 1, 4'b0000, 0);
    step(0, 0, 1, 4'b0000, 0);
    step(0, 0, 1, 4'b0001, 0);
    step(0, 0, 1, 4'b0000, 0);
    chk_out("b2b_vote", 4'b0000, 1, 1);
    step(0, 0, 0, '0, 1);

    // Abort coincident with final sample
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 1, 1, 4'b1111, 0);
    chk_out("abort_last", 4'b0000, 0, 0);
    step(0, 0, 1, 4'b1111, 0);
    step(0, 0, 1, 4'b1111, 0);
    chk_out("abort_idle", 4'b0000, 0, 0);
    step(1, 1, 0, '0, 0);
    chk_out("abort_beats_start", 4'b0000, 0, 0);

    // Abort in HOLD drops valid, keeps latched vote
    window(4'b1010, 4'b1010, 4'b1010, 4'b1010);
    chk_out("pre_hold_abort", 4'b1010, 1, 1);
    step(0, 1, 0, '0, 0);
    chk_out("hold_abort", 4'b1010, 0, 0);

    // Async reset mid-window discards it
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 4'b0101, 0);
    step(0, 0, 1, 4'b0101, 0);
    rst_n = 0;
    #2;
    chk_out("async_reset", 4'b0000, 0, 0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 4'b0101, 0);
    step(0, 0, 1, 4'b0101, 0);
    step(0, 0, 1, 4'b0101, 0);
    chk_out("post_reset_pending", 4'b0000, 0, 1);
    step(0, 0, 1, 4'b0101, 0);
    chk_out("post_reset_vote", 4'b0101, 1, 1);
    step(0, 0, 0, '0, 1);

    // SAMPLES=1 instance
    start1 = 1;
    @(posedge clk); #1;
    start1 = 0; cmp_valid1 = 1; comparison1 = 4'b1010;
    @(posedge clk); #1;
    cmp_valid1 = 0;
    chk("s1_spins", 32'(spins1), 32'h0000_000a);
    chk("s1_valid", 32'(spins_valid1), 32'h1);
    chk("s1_busy", 32'(busy1), 32'h1);
    spins_ready1 = 1;
    @(posedge clk); #1;
    spins_ready1 = 0;
    chk("s1_accept", 32'(spins_valid1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
